// File: rtl/luma_fir_8tap_if.sv
// luma_fir_8tap_if: tagged multi-flux FIFO read/write interfaces
// read_interface: per-flux data word and empty flag in, per-flux read strobe out.
// write_interface: one tagged din word and write strobe out, per-flux full flag in.
interface read_interface #(
    parameter int W    = 9,
    parameter int FLUX = 2
);
    logic [FLUX-1:0][W-1:0] data;
    logic [FLUX-1:0]        empty;
    logic [FLUX-1:0]        read;
    modport actor (input data, input empty, output read);
    modport fifo  (output data, output empty, input read);
endinterface

interface write_interface #(
    parameter int W    = 17,
    parameter int FLUX = 2
);
    logic [W-1:0]    din;
    logic            write;
    logic [FLUX-1:0] full;
    modport actor (output din, output write, input full);
    modport fifo  (input din, input write, output full);
endinterface

// File: rtl/luma_fir_8tap.sv
// luma_fir_8tap: multi-flux 8-tap HEVC luma interpolation filter
// clk, rst            : clock, synchronous active-high reset
// read_port_c0..c7    : tagged signed 9-bit coefficients, one FIFO per tap
// read_port_sample    : tagged unsigned 8-bit reference samples
// write_port_out      : {tag, signed 16-bit filtered value}
module luma_fir_8tap #(
    parameter int FLUX      = 2,
    parameter int ROW_LEN   = 8,
    parameter int TAG_WIDTH = (FLUX > 1) ? $clog2(FLUX) : 1
) (
    input  logic          clk,
    input  logic          rst,
    read_interface.actor  read_port_c0,
    read_interface.actor  read_port_c1,
    read_interface.actor  read_port_c2,
    read_interface.actor  read_port_c3,
    read_interface.actor  read_port_c4,
    read_interface.actor  read_port_c5,
    read_interface.actor  read_port_c6,
    read_interface.actor  read_port_c7,
    read_interface.actor  read_port_sample,
    write_interface.actor write_port_out
);
    localparam int RW = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
    localparam int GW = (FLUX > 1) ? $clog2(FLUX) : 1;

    typedef enum logic [1:0] {LOAD, FILL, RUN} state_t;

    state_t                          st     [FLUX];
    state_t                          st_nxt [FLUX];
    logic [2:0]                      fill_cnt [FLUX];
    logic [RW-1:0]                   row_cnt  [FLUX];
    logic signed [8:0]               coef [FLUX][8];
    logic [7:0]                      hist [FLUX][7];
    logic [FLUX-1:0][TAG_WIDTH+8:0]  coef_data [8];
    logic [FLUX-1:0]                 coef_empty, rdy, coef_rd, smp_rd;
    logic                            any, wr;
    logic [GW-1:0]                   g;
    logic [7:0]                      smp;
    logic signed [17:0]              prod [8];
    logic signed [19:0]              acc;
    logic                            unused_bits;

    assign coef_data[0] = read_port_c0.data;
    assign coef_data[1] = read_port_c1.data;
    assign coef_data[2] = read_port_c2.data;
    assign coef_data[3] = read_port_c3.data;
    assign coef_data[4] = read_port_c4.data;
    assign coef_data[5] = read_port_c5.data;
    assign coef_data[6] = read_port_c6.data;
    assign coef_data[7] = read_port_c7.data;

    // a coefficient set is only available once every tap FIFO has a word
    assign coef_empty = read_port_c0.empty | read_port_c1.empty | read_port_c2.empty
                      | read_port_c3.empty | read_port_c4.empty | read_port_c5.empty
                      | read_port_c6.empty | read_port_c7.empty;

    assign read_port_c0.read     = coef_rd;
    assign read_port_c1.read     = coef_rd;
    assign read_port_c2.read     = coef_rd;
    assign read_port_c3.read     = coef_rd;
    assign read_port_c4.read     = coef_rd;
    assign read_port_c5.read     = coef_rd;
    assign read_port_c6.read     = coef_rd;
    assign read_port_c7.read     = coef_rd;
    assign read_port_sample.read = smp_rd;
    assign write_port_out.write  = wr;
    assign write_port_out.din    = wr ? {TAG_WIDTH'(g), acc[15:0]} : 'x;

    // tags are ignored on input: the port/flux index identifies the stream
    assign unused_bits = ^{read_port_sample.data, coef_data[0], coef_data[1], coef_data[2],
                           coef_data[3], coef_data[4], coef_data[5], coef_data[6],
                           coef_data[7], acc[19:16]};

    always_comb begin
        for (int i = 0; i < FLUX; i++)
            rdy[i] = st[i] == LOAD ? !coef_empty[i] :
                     st[i] == FILL ? !read_port_sample.empty[i] :
                     !read_port_sample.empty[i] && !write_port_out.full[i];
    end

    // descending scan so the lowest ready index wins
    always_comb begin
        any = 1'b0;
        g   = '0;
        for (int i = FLUX - 1; i >= 0; i--)
            if (rdy[i]) begin
                any = 1'b1;
                g   = GW'(i);
            end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < FLUX; i++)
            st[i] <= rst ? LOAD : st_nxt[i];
    end

    always_comb begin
        for (int i = 0; i < FLUX; i++)
            st_nxt[i] = st[i];
        if (any)
            st_nxt[g] = st[g] == LOAD ? FILL :
                        st[g] == FILL ? (fill_cnt[g] == 3'd6 ? RUN : FILL) :
                        (row_cnt[g] == RW'(ROW_LEN - 1) ? LOAD : RUN);
    end

    always_comb begin
        coef_rd = '0;
        smp_rd  = '0;
        wr      = 1'b0;
        if (any && !rst) begin
            coef_rd[g] = st[g] == LOAD;
            smp_rd[g]  = st[g] != LOAD;
            wr         = st[g] != LOAD && st[g] != FILL;
        end
    end

    // window: h[0] (oldest) .. h[6], then the sample being read this cycle
    always_comb begin
        smp = read_port_sample.data[g][7:0];
        for (int j = 0; j < 7; j++)
            prod[j] = 18'(coef[g][j]) * 18'($signed({1'b0, hist[g][j]}));
        prod[7] = 18'(coef[g][7]) * 18'($signed({1'b0, smp}));
        acc = '0;
        for (int j = 0; j < 8; j++)
            acc = acc + 20'(prod[j]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FLUX; i++) begin
                fill_cnt[i] <= '0;
                row_cnt[i]  <= '0;
                for (int j = 0; j < 8; j++)
                    coef[i][j] <= '0;
                for (int j = 0; j < 7; j++)
                    hist[i][j] <= '0;
            end
        end else if (any) begin
            if (st[g] == LOAD) begin
                for (int j = 0; j < 8; j++)
                    coef[g][j] <= $signed(coef_data[j][g][8:0]);
                fill_cnt[g] <= '0;
            end else begin
                for (int j = 0; j < 6; j++)
                    hist[g][j] <= hist[g][j+1];
                hist[g][6] <= smp;
                if (st[g] == FILL) begin
                    fill_cnt[g] <= fill_cnt[g] + 3'd1;
                    if (fill_cnt[g] == 3'd6)
                        row_cnt[g] <= '0;
                end else begin
                    row_cnt[g] <= row_cnt[g] + RW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_luma_fir_8tap.sv
// tb_luma_fir_8tap: randomized and directed check of luma_fir_8tap against a row-level model
module tb_luma_fir_8tap;
    localparam int FLUX    = 2;
    localparam int ROW_LEN = 8;
    localparam int RS      = ROW_LEN + 7;

    typedef logic [71:0] cset_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    read_interface  #(.W(10), .FLUX(FLUX)) c_if [8] ();
    read_interface  #(.W(9),  .FLUX(FLUX)) s_if ();
    write_interface #(.W(17), .FLUX(FLUX)) o_if ();

    logic [FLUX-1:0][9:0] cf_data [8];
    logic [FLUX-1:0]      cf_empty;
    logic [FLUX-1:0]      cf_rd [8];

    for (genvar j = 0; j < 8; j++) begin : g_c
        assign c_if[j].data  = cf_data[j];
        assign c_if[j].empty = cf_empty;
        assign cf_rd[j]      = c_if[j].read;
    end

    luma_fir_8tap #(.FLUX(FLUX), .ROW_LEN(ROW_LEN)) dut (
        .clk(clk), .rst(rst),
        .read_port_c0(c_if[0]), .read_port_c1(c_if[1]), .read_port_c2(c_if[2]),
        .read_port_c3(c_if[3]), .read_port_c4(c_if[4]), .read_port_c5(c_if[5]),
        .read_port_c6(c_if[6]), .read_port_c7(c_if[7]),
        .read_port_sample(s_if), .write_port_out(o_if)
    );

    cset_t       cq     [FLUX][$];
    logic [7:0]  sq     [FLUX][$];
    cset_t       m_sets [FLUX][$];
    logic [7:0]  m_smp  [FLUX][$];
    logic [15:0] out_q  [FLUX][$];
    int          wr_cyc [FLUX][$];
    int          out_cnt [FLUX];
    int          cs [8];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          c0, base;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        assert (act === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // output n of a flux: row n/ROW_LEN, window starts at sample k of that row's 15
    function automatic logic [15:0] model_y(input int f, input int n);
        int r = n / ROW_LEN;
        int k = n % ROW_LEN;
        int a = 0;
        for (int j = 0; j < 8; j++)
            a += int'($signed(m_sets[f][r][9*j +: 9])) * int'(m_smp[f][r*RS + k + j]);
        return a[15:0];
    endfunction

    task automatic push_set(input int f);
        cset_t s;
        for (int j = 0; j < 8; j++) s[9*j +: 9] = 9'(cs[j]);
        cq[f].push_back(s);
        m_sets[f].push_back(s);
    endtask

    task automatic push_smp(input int f, input logic [7:0] v);
        sq[f].push_back(v);
        m_smp[f].push_back(v);
    endtask

    task automatic rand_row(input int f);
        for (int j = 0; j < 8; j++) cs[j] = int'($urandom_range(0, 511)) - 256;
        push_set(f);
        for (int k = 0; k < RS; k++) push_smp(f, 8'($urandom));
    endtask

    task automatic drive();
        for (int f = 0; f < FLUX; f++) begin
            s_if.empty[f] = sq[f].size() == 0;
            cf_empty[f]   = cq[f].size() == 0;
            s_if.data[f]  = {1'(f), 8'h00};
            if (sq[f].size() != 0) s_if.data[f] = {1'(f), sq[f][0]};
            for (int j = 0; j < 8; j++) begin
                cf_data[j][f] = {1'($urandom), 9'h000};
                if (cq[f].size() != 0) cf_data[j][f] = {1'($urandom), cq[f][0][9*j +: 9]};
            end
        end
    endtask

    task automatic tick();
        logic [FLUX-1:0] crd, srd;
        int f;
        @(negedge clk);
        crd = cf_rd[0];
        srd = s_if.read;
        for (int j = 1; j < 8; j++) check("coef_ports_agree", cf_rd[j], crd);
        check("no_underflow", {crd & cf_empty, srd & s_if.empty}, 0);
        check("one_action", ($countones(crd) + $countones(srd)) <= 1, 1);
        if (rst) check("rst_quiet", {crd, srd, o_if.write}, 0);
        if (o_if.write) begin
            f = int'(o_if.din[16]);
            check("wr_with_read", srd[f], 1);
            check("wr_not_full", o_if.full[f], 0);
            check("out_y", o_if.din[15:0], model_y(f, out_cnt[f]));
            out_q[f].push_back(o_if.din[15:0]);
            wr_cyc[f].push_back(cyc);
            out_cnt[f]++;
        end
        cyc++;
        @(posedge clk);
        #1;
        for (int i = 0; i < FLUX; i++) begin
            if (crd[i]) void'(cq[i].pop_front());
            if (srd[i]) void'(sq[i].pop_front());
        end
        drive();
    endtask

    task automatic run_until(input int f, input int target, input int limit);
        for (int i = 0; i < limit && out_cnt[f] < target; i++) tick();
    endtask

    initial begin
        o_if.full = '0;
        for (int f = 0; f < FLUX; f++) out_cnt[f] = 0;
        // copy filter queued before reset: nothing may be popped while rst is high
        cs = '{0, 0, 0, 64, 0, 0, 0, 0};
        push_set(0);
        for (int k = 0; k < RS; k++) push_smp(0, 8'(10 + k));
        drive();
        repeat (3) tick();
        check("rst_no_pop", sq[0].size(), RS);
        rst = 1'b0;
        c0 = cyc;
        run_until(0, 8, 40);
        check("copy_cnt", out_cnt[0], 8);
        check("copy_first", out_q[0][0], 832);
        check("copy_second", out_q[0][1], 896);
        check("copy_latency", wr_cyc[0][0] - c0, 8);
        check("copy_burst", wr_cyc[0][7] - wr_cyc[0][0], 7);

        cs = '{-1, 4, -11, 40, 40, -11, 4, -1};
        push_set(0);
        for (int k = 0; k < RS; k++) push_smp(0, 8'd100);
        run_until(0, 16, 40);
        check("dc_cnt", out_cnt[0], 16);
        check("dc_first", out_q[0][8], 16'h1900);
        check("dc_last", out_q[0][15], 16'h1900);

        cs = '{-1, 4, -10, 58, 17, -5, 1, 0};
        push_set(0);
        push_set(0);
        for (int k = 0; k < RS; k++) push_smp(0, k == 2 ? 8'd255 : 8'd0);
        for (int k = 0; k < RS; k++) push_smp(0, (k >= 4 && k < 8) ? 8'd255 : 8'd0);
        run_until(0, 32, 60);
        check("sign_cnt", out_cnt[0], 32);
        check("sign_neg", out_q[0][16], 16'hF60A);
        check("sign_pos", out_q[0][24], 16'd3315);

        // flux 0 blocked by a full output FIFO must not hold up flux 1
        o_if.full[0] = 1'b1;
        rand_row(0);
        rand_row(1);
        rand_row(1);
        run_until(1, 16, 80);
        check("iso_f1_cnt", out_cnt[1], 16);
        check("iso_f0_held", out_cnt[0], 32);
        check("iso_f0_fill_only", sq[0].size(), RS - 7);
        check("iso_f1_burst", wr_cyc[1][15] - wr_cyc[1][8], 7);
        o_if.full[0] = 1'b0;
        run_until(0, 40, 30);
        check("iso_f0_resume", out_cnt[0], 40);

        // one set, two rows of samples: only one row may be consumed
        cs = '{0, 1, -5, 17, 58, -10, 4, -1};
        push_set(0);
        for (int k = 0; k < 2 * RS; k++) push_smp(0, 8'($urandom));
        repeat (40) tick();
        check("rb_cnt", out_cnt[0], 48);
        check("rb_left", sq[0].size(), RS);
        c0 = cyc;
        push_set(0);
        drive();
        run_until(0, 56, 30);
        check("rb_cnt2", out_cnt[0], 56);
        check("rb_refill", wr_cyc[0][48] - c0, 8);
        check("rb_empty", sq[0].size(), 0);

        // random rows on both fluxes with output back-pressure
        for (int r = 0; r < 4; r++) begin
            rand_row(0);
            rand_row(1);
        end
        for (int i = 0; i < 400 && (out_cnt[0] < 88 || out_cnt[1] < 48); i++) begin
            o_if.full = 2'($urandom);
            tick();
        end
        o_if.full = '0;
        run_until(0, 88, 40);
        run_until(1, 48, 40);
        check("rnd_cnt0", out_cnt[0], 88);
        check("rnd_cnt1", out_cnt[1], 48);

        // reset after three outputs of a row aborts it
        rand_row(0);
        base = out_cnt[0];
        run_until(0, base + 3, 30);
        check("mid_three", out_cnt[0], base + 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int f = 0; f < FLUX; f++) begin
            cq[f].delete(); sq[f].delete(); m_sets[f].delete(); m_smp[f].delete();
            out_q[f].delete(); wr_cyc[f].delete(); out_cnt[f] = 0;
        end
        cs = '{0, 0, 0, 64, 0, 0, 0, 0};
        push_set(0);
        for (int k = 0; k < RS; k++) push_smp(0, 8'(200 + k));
        drive();
        c0 = cyc;
        run_until(0, 8, 40);
        check("post_rst_cnt", out_cnt[0], 8);
        check("post_rst_latency", wr_cyc[0][0] - c0, 8);
        check("post_rst_first", out_q[0][0], 16'(64 * 203));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/luma_fir_8tap.md
# luma_fir_8tap

Multi-flux 8-tap HEVC luma interpolation filter that consumes the eight tagged coefficient streams (c0..c7) emitted by the luma coefficient generator and applies each coefficient set to a stream of 8-bit reference samples. It sits directly downstream of the coefficient generator in the parallel HEVC dataflow. Per flux it holds a coefficient bank, a 7-sample history and a row counter. Flux arbitration is lowest-index-ready-first, one action per cycle.

## Interface
- FLUX, 2: number of independent tagged data fluxes sharing the block.
- ROW_LEN, 8: filtered outputs produced per coefficient set (≥1).
- TAG_WIDTH, $clog2(FLUX) (0 when MONO is defined): tag field width in MSBs of every FIFO word.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- read_port_c0 .. read_port_c7  read_interface.actor  TAG_WIDTH+9  signed 9-bit coefficient in LSBs; empty[FLUX] in, read[FLUX] out.
- read_port_sample  read_interface.actor  TAG_WIDTH+8  unsigned 8-bit sample in LSBs; empty[FLUX] in, read[FLUX] out.
- write_port_out  write_interface.actor  TAG_WIDTH+16  {tag, signed 16-bit filtered value}; full[FLUX] in, write out.

## Operation
- Per-flux state: LOAD, FILL, RUN; 3-bit fill counter; row counter sized for ROW_LEN; eight 9-bit coefficient registers; 7×8-bit shift register h[0] (oldest) .. h[6] (newest).
- Flux i ready:
  - LOAD: all of c0..c7 empty[i]==0.
  - FILL: sample empty[i]==0.
  - RUN: sample empty[i]==0 and out full[i]==0.
- Grant: lowest ready i. None ready → no reads, write=0, din='x.
- LOAD grant: read[i]=1 on all eight coefficient ports; coefficients latched; fill counter←0; state←FILL.
- FILL grant: sample read[i]=1; shift in sample; counter+1; after 7th sample, state←RUN, row counter←0.
- RUN grant: sample read[i]=1 and write=1 in the same cycle. din={i, y}, where y = Σ c_j·w_j and window w_0..w_7 = h[0..6], incoming sample. Sample is then shifted in; row counter+1. After the ROW_LEN-th output, state←LOAD.
- Arithmetic: coefficient signed 9b × sample zero-extended → signed 18b products; signed 20b sum; y = low 16 bits. Exact for all valid HEVC luma sets (|y| ≤ 22440).
- Sample order: the first sample read is the oldest (multiplied by c0 when the window is full).
- Row boundary: no carry-over. Each new row's FILL discards old history by shifting in 7 fresh samples.
- read[j] is 0 for every non-granted flux and for every port not used by the granted action. Coefficient tags are ignored; the port index defines the flux.
- Reset: all fluxes → LOAD, counters 0, coefficient and history registers 0. While rst=1, all read[]=0 and write=0.

## Timing
- Handshake is combinational, as on all FIFO actors: read/write asserted in the cycle the condition holds; FIFO pops/pushes at the next edge.
- Latency: an output appears in the same cycle its newest sample is read. Zero pipeline bubbles while a flux stays granted.
- Row cost per flux: 1 LOAD cycle + 7 FILL cycles + ROW_LEN RUN cycles.
- Starved fluxes hold all state indefinitely.
- A full output FIFO on flux i stalls only i's RUN reads; other fluxes proceed.
- rst asserted mid-row aborts the row at the next edge. Partially consumed FIFO contents are not re-read; upstream must be reset together with this block.
- Single-cycle actions per flux: at most one sample, one coefficient set or one output per cycle in total.

## Test plan
- Copy filter: flux 0, coefficients {0,0,0,64,0,0,0,0}, samples 10,11,12,… → after 7 fill cycles, outputs {0,832},{0,896},… (64·s[k+3]). 8 outputs, then LOAD.
- DC gain: coefficients {-1,4,-11,40,40,-11,4,-1}, 15 samples of 100 → 8 outputs of 6400 (0x1900).
- Sign and width: coefficients {-1,4,-10,58,17,-5,1,0}, samples 0,0,255,0,0,0,0,0 → first output 0xF60A (-2550). Samples 0,0,0,0,255,255,255,255 → 3315.
- Flux isolation: FLUX=2, out full[0]=1 during flux 0 RUN, flux 1 fed continuously → flux 1 outputs tagged 1 every cycle, flux 0 read[0]=0. On full[0] release, flux 0 resumes with correct next value.
- Row boundary: ROW_LEN=8, sample FIFO holds 30 entries, coefficient FIFO one set → exactly 15 samples consumed, then no reads until a second set arrives. The second row needs 7 fresh fill samples.
- Reset mid-row: rst pulsed after 3 RUN outputs → next cycle no reads/writes. Afterwards the flux requires a new LOAD and 7 fills before any output.
